deal_controller: RTL and testbench

DEAL_CONTROLLER -- requirements
Module: deal_controller

---
 rtl/deal_controller.sv | 139 +++++++++++++
 tb/tb_deal_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/deal_controller.sv
// deal_controller: Baccarat dealing sequencer (Moore FSM).
// Steps the datapath through loading two cards each for player and dealer,
// applies the third-card rules, then shows the result on the win lights.
// Optional debug port: define DEAL_STATE_DEBUG_EN to expose the state as state_dbg.
module deal_controller (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
`ifdef DEAL_STATE_DEBUG_EN
    output logic [3:0] state_dbg,
`endif
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light
);

    typedef enum logic [3:0] {
        StP1   = 4'd0,
        StD1   = 4'd1,
        StP2   = 4'd2,
        StD2   = 4'd3,
        StEval = 4'd4,
        StP3   = 4'd5,
        StBank = 4'd6,
        StD3   = 4'd7,
        StDone = 4'd8
    } state_e;

    state_e state_q, state_d;

    logic       natural;
    logic       p_low;
    logic       p_stand;
    logic       d_low;
    logic [3:0] bank_v;
    logic       dealer_draws;

    // Score classification; scores 10-15 fall into none of these buckets.
    always_comb begin
        natural = ((pscore >= 4'd8) && (pscore <= 4'd9)) ||
                  ((dscore >= 4'd8) && (dscore <= 4'd9));
        p_low   = (pscore <= 4'd5);
        p_stand = (pscore == 4'd6) || (pscore == 4'd7);
        d_low   = (dscore <= 4'd5);
    end

    // Banker third-card rule, keyed on the player's third card value.
    always_comb begin
        bank_v       = 4'd0;
        dealer_draws = 1'b0;
        // Face cards (10-13) and "no card" count as zero.
        if ((pcard3 >= 4'd1) && (pcard3 <= 4'd9)) begin
            bank_v = pcard3;
        end
        case (dscore)
            4'd0, 4'd1, 4'd2: dealer_draws = 1'b1;
            4'd3:             dealer_draws = (bank_v != 4'd8);
            4'd4:             dealer_draws = (bank_v >= 4'd2) && (bank_v <= 4'd7);
            4'd5:             dealer_draws = (bank_v >= 4'd4) && (bank_v <= 4'd7);
            4'd6:             dealer_draws = (bank_v >= 4'd6) && (bank_v <= 4'd7);
            default:          dealer_draws = 1'b0;
        endcase
    end

    // State register; reset forces the first load state immediately.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= StP1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = StP1;
        case (state_q)
            StP1:   state_d = StD1;
            StD1:   state_d = StP2;
            StP2:   state_d = StD2;
            StD2:   state_d = StEval;
            StEval: begin
                if (natural) begin
                    state_d = StDone;
                end else if (p_low) begin
                    state_d = StP3;
                end else if (p_stand && d_low) begin
                    state_d = StD3;
                end else begin
                    state_d = StDone;
                end
            end
            StP3:   state_d = StBank;
            StBank: state_d = dealer_draws ? StD3 : StDone;
            StD3:   state_d = StDone;
            StDone: state_d = StDone;
            // Unused encodings recover to the start of a hand.
            default: state_d = StP1;
        endcase
    end

    // Moore outputs: one load enable per load state, lights only when done.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        case (state_q)
            StP1:   load_pcard1 = 1'b1;
            StD1:   load_dcard1 = 1'b1;
            StP2:   load_pcard2 = 1'b1;
            StD2:   load_dcard2 = 1'b1;
            StP3:   load_pcard3 = 1'b1;
            StD3:   load_dcard3 = 1'b1;
            StDone: begin
                // A tie lights both.
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
            default: ;
        endcase
    end

`ifdef DEAL_STATE_DEBUG_EN
    assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_deal_controller.sv
// Testbench for deal_controller: directed hands with a scoreboard.
// Stimulus pushes the expected (cycle, output vector) events of each hand;
// a negedge monitor pops and compares whenever a load or a new result shows.
module tb_deal_controller;

    logic       slow_clock;
    logic       resetb;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
`ifdef DEAL_STATE_DEBUG_EN
    logic [3:0] state_dbg;
`endif

    deal_controller dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
`ifdef DEAL_STATE_DEBUG_EN
        .state_dbg        (state_dbg),
`endif
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    localparam logic [7:0] V_P1 = 8'b1000_0000;
    localparam logic [7:0] V_D1 = 8'b0100_0000;
    localparam logic [7:0] V_P2 = 8'b0010_0000;
    localparam logic [7:0] V_D2 = 8'b0001_0000;
    localparam logic [7:0] V_P3 = 8'b0000_1000;
    localparam logic [7:0] V_D3 = 8'b0000_0100;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } ev_t;

    ev_t        exp_q[$];
    int         checks;
    int         errors;
    int         cyc;
    string      cur_name;
    logic [7:0] prev;
    logic [7:0] obs;

    assign obs = {load_pcard1, load_dcard1, load_pcard2, load_dcard2,
                  load_pcard3, load_dcard3, player_win_light, dealer_win_light};

    initial begin
        slow_clock = 1'b0;
        forever #5 slow_clock = ~slow_clock;
    end

    // Cycles since reset release; the first load state is cycle 0.
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Monitor: every load cycle, and the first cycle of each new result, is an event.
    always @(negedge slow_clock) begin
        if (!resetb) begin
            prev = 8'b0;
        end else begin
            if (obs != 8'b0 && ((|obs[7:2]) || obs != prev)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s: unexpected output at cycle %0d got %b, expected none",
                             cur_name, cyc, obs);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec != obs) begin
                        errors++;
                        $display("FAIL %s: got cycle %0d vec %b, expected cycle %0d vec %b",
                                 cur_name, cyc, obs, e.cyc, e.vec);
                    end
                end
            end
            prev = obs;
        end
    end

    task automatic push(input int c, input logic [7:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    task automatic check_drained();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events never seen, expected 0",
                     cur_name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_cycle(input int target);
        int guard;
        guard = 0;
        while (cyc != target && guard < 40) begin
            @(posedge slow_clock);
            #1;
            guard++;
        end
        if (cyc != target) begin
            checks++;
            errors++;
            $display("FAIL %s: cycle counter got %0d, expected %0d", cur_name, cyc, target);
        end
    endtask

    // One hand: opening scores, player third card, final scores, expected draws and lights.
    task automatic run_hand(input string nm, input logic [3:0] ps0, input logic [3:0] ds0,
                            input logic [3:0] pc3, input logic [3:0] psf,
                            input logic [3:0] dsf, input bit p3, input bit d3,
                            input bit pw, input bit dw);
        int c;
        cur_name = nm;
        resetb   = 1'b0;
        pscore   = ps0;
        dscore   = ds0;
        pcard3   = pc3;
        @(posedge slow_clock);
        #1;
        push(0, V_P1);
        push(1, V_D1);
        push(2, V_P2);
        push(3, V_D2);
        c = 5;
        if (p3) begin
            push(5, V_P3);
            c = 7;
        end
        if (d3) begin
            push(c, V_D3);
            c++;
        end
        push(c, {6'b0, pw, dw});
        resetb = 1'b1;
        wait_cycle(c);
        // Scores settle after the last decision edge, as the datapath would.
        pscore = psf;
        dscore = dsf;
        repeat (4) begin
            @(posedge slow_clock);
            #1;
        end
        check_drained();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cur_name = "reset";
        prev     = 8'b0;
        resetb   = 1'b0;
        pscore   = 4'd0;
        dscore   = 4'd0;
        pcard3   = 4'd0;
        #1;
        checks++;
        if (obs != V_P1) begin
            errors++;
            $display("FAIL reset_outputs: got %b, expected %b", obs, V_P1);
        end
`ifdef DEAL_STATE_DEBUG_EN
        checks++;
        if (state_dbg != 4'd0) begin
            errors++;
            $display("FAIL reset_state_dbg: got %0d, expected 0", state_dbg);
        end
`endif
        repeat (2) @(posedge slow_clock);
        #1;

        //       name           ps0    ds0    pc3     psf    dsf    p3 d3 pw dw
        run_hand("natural_p",   4'd8,  4'd7,  4'd0,  4'd8,  4'd7,  0, 0, 1, 0);
        run_hand("stand_d3",    4'd7,  4'd4,  4'd0,  4'd7,  4'd7,  0, 1, 1, 1);
        run_hand("bank_pc7",    4'd3,  4'd6,  4'd7,  4'd0,  4'd9,  1, 1, 0, 1);
        run_hand("bank_pc12",   4'd3,  4'd6,  4'd12, 4'd3,  4'd6,  1, 0, 0, 1);
        run_hand("d3_pc8",      4'd2,  4'd3,  4'd8,  4'd0,  4'd3,  1, 0, 0, 1);
        run_hand("d3_pc9",      4'd1,  4'd3,  4'd9,  4'd0,  4'd2,  1, 1, 0, 1);
        run_hand("natural_d",   4'd5,  4'd9,  4'd0,  4'd5,  4'd9,  0, 0, 0, 1);
        run_hand("stand_tie",   4'd6,  4'd6,  4'd0,  4'd6,  4'd6,  0, 0, 1, 1);
        run_hand("stand_d5",    4'd7,  4'd5,  4'd0,  4'd7,  4'd5,  0, 1, 1, 0);
        run_hand("d4_pc1",      4'd0,  4'd4,  4'd1,  4'd1,  4'd4,  1, 0, 0, 1);
        run_hand("d5_pc4",      4'd5,  4'd5,  4'd4,  4'd9,  4'd8,  1, 1, 1, 0);
        run_hand("d12_range",   4'd3,  4'd12, 4'd5,  4'd8,  4'd12, 1, 0, 0, 1);
        run_hand("d2_pc8",      4'd4,  4'd2,  4'd8,  4'd2,  4'd9,  1, 1, 0, 1);
        run_hand("d7_pc6",      4'd3,  4'd7,  4'd6,  4'd9,  4'd7,  1, 0, 1, 0);

        // Abort mid-hand: reset between edges while loading pcard2.
        cur_name = "reset_mid";
        resetb   = 1'b0;
        pscore   = 4'd1;
        dscore   = 4'd1;
        pcard3   = 4'd0;
        @(posedge slow_clock);
        #1;
        push(0, V_P1);
        push(1, V_D1);
        resetb = 1'b1;
        wait_cycle(2);
        #1;
        resetb = 1'b0;
        #1;
        checks++;
        if (obs != V_P1) begin
            errors++;
            $display("FAIL reset_mid_outputs: got %b, expected %b", obs, V_P1);
        end
        repeat (2) begin
            @(posedge slow_clock);
            #1;
        end
        check_drained();
        run_hand("after_reset", 4'd9,  4'd2,  4'd0,  4'd9,  4'd2,  0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
